mac_out_requant: RTL

//  Downstream drain stage of the 5x5 systolic MAC array. Captures each 80-bit result vector
//  (5 lanes x 16-bit unsigned) on VAL_i and requantizes every lane (round, shift, saturate to 8 bit).

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_out_requant_if.sv | 29 ++
 rtl/mac_out_fifo.sv | 73 +++++++
 rtl/mac_out_requant.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array drain path.
// Holds the lane geometry, the requantized entry layout and the lane slice
// helpers. Lane 0 always sits in the most significant slice of a packed word.
package mac_pkg;

    localparam int unsigned LANES   = 5;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned ACT_W   = 8;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned IN_W    = LANES * ACC_W;
    localparam int unsigned OUT_W   = LANES * ACT_W;

    // One buffered result: upstream overflow, per-lane saturation (MSB = lane 0), packed data.
    typedef struct packed {
        logic             ov;
        logic [LANES-1:0] sat;
        logic [OUT_W-1:0] data;
    } requant_t;

    localparam int unsigned ENTRY_W = $bits(requant_t);

    // Lane idx of an accumulator-wide result vector.
    function automatic logic [ACC_W-1:0] acc_lane(input logic [IN_W-1:0] vec,
                                                  input int unsigned    idx);
        return vec[(LANES-1-idx)*ACC_W +: ACC_W];
    endfunction

    // Lane idx of an activation-wide packed word.
    function automatic logic [ACT_W-1:0] act_lane(input logic [OUT_W-1:0] vec,
                                                  input int unsigned     idx);
        return vec[(LANES-1-idx)*ACT_W +: ACT_W];
    endfunction

endpackage

// File: rtl/mac_out_requant_if.sv
// Output stream of the requantizing drain stage.
//   out_data_o  [39:0] packed 8-bit lanes, lane0 = [39:32]
//   out_ov_o           upstream overflow flag of the head entry
//   out_sat_o   [4:0]  per-lane saturation of the head entry, bit4 = lane0
//   out_valid_o        head entry present
//   out_ready_i        consumer accepts the head entry
//   out_last_o         head entry is the final vector of its frame
// master = producer (drain stage), slave = consumer.
interface mac_out_requant_if;
    import mac_pkg::*;

    logic [OUT_W-1:0] out_data_o;
    logic             out_ov_o;
    logic [LANES-1:0] out_sat_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;

    modport master (
        output out_data_o, out_ov_o, out_sat_o, out_valid_o, out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o, out_ov_o, out_sat_o, out_valid_o, out_last_o,
        output out_ready_i
    );

endinterface

// File: rtl/mac_out_fifo.sv
// Synchronous FIFO with arbitrary (non power of two) depth.
//   CLK, RSTN  clock, asynchronous active-low reset
//   clr        synchronous flush (pointers and level to zero)
//   push, din  write request; accepted when not full, or when a pop happens in the same cycle
//   pop        read request; ignored when empty
//   dout       head entry (holds stale data while empty)
//   full, empty, level  occupancy status, level in 0..DEPTH
module mac_out_fifo #(
    parameter int unsigned WIDTH = 46,
    parameter int unsigned DEPTH = 10
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers wrap explicitly since DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                level <= level + LVL_W'(1);
            end else if (rd_en && !wr_en) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/mac_out_requant.sv
// Drain stage of the 5x5 systolic MAC array.
// Each valid 80-bit result vector is rounded, right-shifted and saturated to
// 8 bits per lane over two register stages, then buffered and streamed out.
//   CLK, RSTN   clock, asynchronous active-low reset
//   clr_i       synchronous flush of pipeline, FIFO, frame counter and drop flag
//   shift_i     right-shift amount, sampled together with VAL_i
//   VAL_i       OUT_i/OV_i valid strobe (no backpressure)
//   OV_i        upstream overflow flag of the vector
//   OUT_i       5 x 16-bit unsigned lanes, lane0 = [79:64]
//   out_bus     output stream (data/ov/sat/valid/ready/last)
//   drop_o      sticky: a vector was lost because the FIFO was full
//   level_o     FIFO occupancy 0..DEPTH
module mac_out_requant
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned T     = 10
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        clr_i,
    input  logic [SHIFT_W-1:0]          shift_i,
    input  logic                        VAL_i,
    input  logic                        OV_i,
    input  logic [IN_W-1:0]             OUT_i,
    mac_out_requant_if.master           out_bus,
    output logic                        drop_o,
    output logic [$clog2(DEPTH+1)-1:0]  level_o
);

    localparam int unsigned CNT_W = (T > 1) ? $clog2(T) : 1;

    logic               s1_valid;
    logic               s1_ov;
    logic [SHIFT_W-1:0] s1_shift;
    logic [ACC_W:0]     s1_r   [LANES];
    logic [ACC_W:0]     r_next [LANES];
    logic [ACC_W:0]     rnd;

    logic [LANES-1:0]   sat_next;
    logic [OUT_W-1:0]   data_next;
    logic               s2_valid;
    requant_t           s2_q;

    requant_t           head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [CNT_W-1:0]   frame_cnt;

    // Round-half-up constant: half an LSB of the shifted result.
    always_comb begin
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (ACC_W+1)'(1) << (shift_i - SHIFT_W'(1));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int unsigned LI = g;
        logic [ACC_W:0] q;

        assign r_next[LI] = {1'b0, acc_lane(OUT_i, LI)} + rnd;
        assign q          = s1_r[LI] >> s1_shift;
        assign sat_next[LANES-1-LI] = |q[ACC_W:ACT_W];
        assign data_next[(LANES-1-LI)*ACT_W +: ACT_W] =
            (|q[ACC_W:ACT_W]) ? '1 : q[ACT_W-1:0];
    end

    assign pop = out_bus.out_ready_i & ~fifo_empty;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid  <= 1'b0;
            s1_ov     <= 1'b0;
            s1_shift  <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_r[i] <= '0;
            end
            s2_valid  <= 1'b0;
            s2_q      <= '0;
            frame_cnt <= '0;
            drop_o    <= 1'b0;
        end else if (clr_i) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            frame_cnt <= '0;
            drop_o    <= 1'b0;
        end else begin
            s1_valid <= VAL_i;
            if (VAL_i) begin
                s1_ov    <= OV_i;
                s1_shift <= shift_i;
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_r[i] <= r_next[i];
                end
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= '{ov: s1_ov, sat: sat_next, data: data_next};
            end
            if (pop) begin
                frame_cnt <= (frame_cnt == CNT_W'(T-1)) ? '0 : frame_cnt + CNT_W'(1);
            end
            // Mirrors the FIFO's own accept rule: full and no pop means the entry is lost.
            if (s2_valid && fifo_full && !pop) begin
                drop_o <= 1'b1;
            end
        end
    end

    mac_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .clr   (clr_i),
        .push  (s2_valid),
        .pop   (pop),
        .din   (s2_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign out_bus.out_data_o  = head.data;
    assign out_bus.out_ov_o    = head.ov;
    assign out_bus.out_sat_o   = head.sat;
    assign out_bus.out_valid_o = ~fifo_empty;
    assign out_bus.out_last_o  = ~fifo_empty & (frame_cnt == CNT_W'(T-1));

endmodule
